pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32: PC width in bits; legal range 8..64.
REQ-002 Parameter JIDX_W, default 26: jump-index width; SHALL satisfy JIDX_W+2 < ADDR_W.
REQ-003 Parameter RESET_PC, default 0: PC loaded at reset; word-aligned.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 fetch_valid  output  1  fetch_pc is a valid fetch request.
REQ-007 fetch_ready  input  1  fetch stage accepts fetch_pc this cycle.
REQ-008 fetch_pc  output  ADDR_W  current fetch address.
REQ-009 redir_valid  input  1  redirect request.
REQ-010 redir_ready  output  1  redirect can be accepted this cycle.
REQ-011 redir_kind  input  2  00 branch, 01 jump, 10 register, 11 reserved (treated as no-op).
REQ-012 redir_base  input  ADDR_W  PC+4 of the redirecting instruction.
REQ-013 redir_imm  input  16  branch offset in words, signed.
REQ-014 redir_jidx  input  JIDX_W  jump index field.
REQ-015 redir_reg  input  ADDR_W  register target.
REQ-016 halt_req  input  1  level request to stop fetching.
REQ-017 halted  output  1  sequencer is in HALTED.
REQ-018 misalign  output  1  one-cycle pulse: register target had nonzero bits [1:0].

Function
REQ-019 States SHALL be BOOT, RUN, HALTED; BOOT lasts exactly one cycle after rst_n deasserts, then RUN.
REQ-020 fetch_valid SHALL be 1 only in RUN.
REQ-021 While fetch_valid=1 and fetch_ready=0, fetch_pc SHALL hold unless a redirect is accepted.
REQ-022 On fetch_valid&fetch_ready with no accepted redirect, fetch_pc SHALL become fetch_pc+4 next cycle, wrapping modulo 2^ADDR_W.
REQ-023 redir_ready SHALL be 1 in RUN and HALTED, 0 in BOOT.
REQ-024 Accepted redirect (redir_valid&redir_ready) SHALL load the target into fetch_pc next cycle, overriding increment; a same-cycle fetch handshake still counts as accepted at the old PC.
REQ-025 Branch target = redir_base + (sign-extended redir_imm << 2), modulo 2^ADDR_W.
REQ-026 Jump target = {redir_base[ADDR_W-1:JIDX_W+2], redir_jidx, 2'b00}.
REQ-027 Register target = redir_reg with bits [1:0] forced to 0; misalign SHALL pulse the next cycle if redir_reg[1:0]!=0.
REQ-028 Reserved kind SHALL be accepted with no PC change and no misalign pulse.
REQ-029 RUN->HALTED when halt_req=1 and (fetch_ready=1 or redirect accepted), applying that cycle's PC update first.
REQ-030 HALTED->RUN the cycle after halt_req=0; a redirect accepted in HALTED updates fetch_pc without leaving HALTED.

Reset
REQ-031 During reset: fetch_pc=RESET_PC, state=BOOT, fetch_valid=0, redir_ready=0, halted=0, misalign=0.
REQ-032 Reset assertion mid-operation SHALL abandon any in-flight fetch or redirect immediately.

Configuration
REQ-033 Macro PC_SEQ_EXC_EN: when defined, adds input exc_req (1), output epc (ADDR_W) and parameter EXC_VECTOR (default 32'h80000180 truncated to ADDR_W).
REQ-034 With PC_SEQ_EXC_EN, exc_req=1 in RUN or HALTED SHALL load fetch_pc=EXC_VECTOR and epc=current fetch_pc, override any redirect, and force RUN; epc resets to 0.
REQ-035 Without PC_SEQ_EXC_EN, those ports and logic SHALL be absent; behaviour otherwise identical.

Structure
REQ-036 Package pc_seq_pkg SHALL hold the redir_kind enum, state enum and constant PC_STEP=4.
REQ-037 Target formation SHALL be a combinational sub-module pc_target_calc; state and PC register stay in pc_sequencer.

Verification
REQ-038 Reset release, fetch_ready=1 constant -> fetch_pc 0,4,8,... starting 2 cycles after release (BOOT then RUN).
REQ-039 fetch_ready=0 for 3 cycles at PC 0x10 -> fetch_pc holds 0x10, then 0x14 after acceptance.
REQ-040 Branch base 0x100, imm 0xFFFF -> next fetch_pc 0xFC; jump base 0xA0000004, jidx 0x10 -> 0xA0000040.
REQ-041 Register redirect redir_reg 0x203 -> fetch_pc 0x200, misalign pulses once.
REQ-042 fetch_pc 0xFFFFFFFC, accepted -> wraps to 0x0; halt_req with fetch_ready=1 -> halted=1, fetch_valid=0, PC advanced once.
REQ-043 With PC_SEQ_EXC_EN, exc_req and redirect in same cycle at PC 0x40 -> fetch_pc=EXC_VECTOR, epc=0x40.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer and its target calculator.
package pc_seq_pkg;

    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        KIND_BRANCH = 2'b00,
        KIND_JUMP   = 2'b01,
        KIND_REG    = 2'b10,
        KIND_RSVD   = 2'b11
    } redir_kind_t;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } seq_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target formation: branch, jump, register and reserved kinds.
module pc_target_calc
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int JIDX_W = 26
) (
    input  logic [1:0]        i_kind,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [15:0]       i_imm,
    input  logic [JIDX_W-1:0] i_jidx,
    input  logic [ADDR_W-1:0] i_reg,
    output logic [ADDR_W-1:0] o_target,
    output logic              o_take,
    output logic              o_misalign
);

    logic [ADDR_W-1:0] w_imm_sext;
    logic [ADDR_W-1:0] w_br_off;

    // Sized cast of a signed value sign-extends (or truncates) to ADDR_W.
    assign w_imm_sext = ADDR_W'($signed(i_imm));
    assign w_br_off   = {w_imm_sext[ADDR_W-3:0], 2'b00};

    always_comb begin
        o_target   = i_base;
        o_take     = 1'b0;
        o_misalign = 1'b0;
        case (redir_kind_t'(i_kind))
            KIND_BRANCH: begin
                o_target = i_base + w_br_off;
                o_take   = 1'b1;
            end
            KIND_JUMP: begin
                o_target = {i_base[ADDR_W-1:JIDX_W+2], i_jidx, 2'b00};
                o_take   = 1'b1;
            end
            KIND_REG: begin
                o_target   = {i_reg[ADDR_W-1:2], 2'b00};
                o_take     = 1'b1;
                o_misalign = |i_reg[1:0];
            end
            default: begin
                o_take = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALTED FSM, fetch handshake and redirects.
// Optional exception entry (exc_req/epc/EXC_VECTOR) is enabled by defining PC_SEQ_EXC_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                JIDX_W   = 26,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef PC_SEQ_EXC_EN
    ,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h80000180)
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    output logic [ADDR_W-1:0] fetch_pc,
    input  logic              redir_valid,
    output logic              redir_ready,
    input  logic [1:0]        redir_kind,
    input  logic [ADDR_W-1:0] redir_base,
    input  logic [15:0]       redir_imm,
    input  logic [JIDX_W-1:0] redir_jidx,
    input  logic [ADDR_W-1:0] redir_reg,
    input  logic              halt_req,
    output logic              halted,
    output logic              misalign,
`ifdef PC_SEQ_EXC_EN
    input  logic              exc_req,
    output logic [ADDR_W-1:0] epc,
`endif
    output seq_state_t        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid/ready are never dependent on the partner's signal here.

    seq_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic              r_misalign, w_misalign_nxt;
    logic              w_redir_acc, w_fetch_acc;
    logic [ADDR_W-1:0] w_target;
    logic              w_take, w_tgt_misalign;
`ifdef PC_SEQ_EXC_EN
    logic [ADDR_W-1:0] r_epc, w_epc_nxt;
`endif

    pc_target_calc #(
        .ADDR_W (ADDR_W),
        .JIDX_W (JIDX_W)
    ) u_target (
        .i_kind     (redir_kind),
        .i_base     (redir_base),
        .i_imm      (redir_imm),
        .i_jidx     (redir_jidx),
        .i_reg      (redir_reg),
        .o_target   (w_target),
        .o_take     (w_take),
        .o_misalign (w_tgt_misalign)
    );

    assign fetch_valid = (r_state == ST_RUN);
    assign redir_ready = (r_state != ST_BOOT);
    assign halted      = (r_state == ST_HALTED);
    assign fetch_pc    = r_pc;
    assign misalign    = r_misalign;
    assign dbg_state   = r_state;
    assign w_redir_acc = redir_valid & redir_ready;
    assign w_fetch_acc = fetch_valid & fetch_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_misalign_nxt = w_redir_acc & w_tgt_misalign;
`ifdef PC_SEQ_EXC_EN
        w_epc_nxt      = r_epc;
`endif
        if (w_fetch_acc) begin
            w_pc_nxt = r_pc + ADDR_W'(PC_STEP);
        end
        if (w_redir_acc && w_take) begin
            w_pc_nxt = w_target;
        end

        case (r_state)
            ST_BOOT:   w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (halt_req && (fetch_ready || w_redir_acc)) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (!halt_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default:   w_state_nxt = ST_BOOT;
        endcase

`ifdef PC_SEQ_EXC_EN
        // Exception entry wins over any redirect and any halt decision.
        if (exc_req && (r_state != ST_BOOT)) begin
            w_pc_nxt       = EXC_VECTOR;
            w_epc_nxt      = r_pc;
            w_state_nxt    = ST_RUN;
            w_misalign_nxt = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

`ifdef PC_SEQ_EXC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epc <= '0;
        end else begin
            r_epc <= w_epc_nxt;
        end
    end

    assign epc = r_epc;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (default parameters, ADDR_W=32, RESET_PC=0).
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int ADDR_W = 32;
    localparam int JIDX_W = 26;

    logic              clk;
    logic              rst_n;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [ADDR_W-1:0] fetch_pc;
    logic              redir_valid;
    logic              redir_ready;
    logic [1:0]        redir_kind;
    logic [ADDR_W-1:0] redir_base;
    logic [15:0]       redir_imm;
    logic [JIDX_W-1:0] redir_jidx;
    logic [ADDR_W-1:0] redir_reg;
    logic              halt_req;
    logic              halted;
    logic              misalign;
    seq_state_t        dbg_state;
`ifdef PC_SEQ_EXC_EN
    logic              exc_req;
    logic [ADDR_W-1:0] epc;
`endif

    int n_vec;
    int n_miss;

    pc_sequencer #(
        .ADDR_W (ADDR_W),
        .JIDX_W (JIDX_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_pc    (fetch_pc),
        .redir_valid (redir_valid),
        .redir_ready (redir_ready),
        .redir_kind  (redir_kind),
        .redir_base  (redir_base),
        .redir_imm   (redir_imm),
        .redir_jidx  (redir_jidx),
        .redir_reg   (redir_reg),
        .halt_req    (halt_req),
        .halted      (halted),
        .misalign    (misalign),
`ifdef PC_SEQ_EXC_EN
        .exc_req     (exc_req),
        .epc         (epc),
`endif
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic redir(input logic [1:0] kind, input logic [31:0] base, input logic [15:0] imm,
                         input logic [25:0] jidx, input logic [31:0] rreg);
        redir_valid = 1'b1;
        redir_kind  = kind;
        redir_base  = base;
        redir_imm   = imm;
        redir_jidx  = jidx;
        redir_reg   = rreg;
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        rst_n       = 1'b0;
        fetch_ready = 1'b1;
        redir_valid = 1'b0;
        redir_kind  = 2'b00;
        redir_base  = '0;
        redir_imm   = '0;
        redir_jidx  = '0;
        redir_reg   = '0;
        halt_req    = 1'b0;
`ifdef PC_SEQ_EXC_EN
        exc_req     = 1'b0;
`endif

        // Reset values
        step();
        step();
        check("rst_pc", 64'(fetch_pc), 64'h0);
        check("rst_fv", 64'(fetch_valid), 64'h0);
        check("rst_rr", 64'(redir_ready), 64'h0);
        check("rst_halted", 64'(halted), 64'h0);
        check("rst_misalign", 64'(misalign), 64'h0);
        check("rst_state", 64'(dbg_state), 64'(ST_BOOT));
`ifdef PC_SEQ_EXC_EN
        check("rst_epc", 64'(epc), 64'h0);
`endif

        // Release: one BOOT cycle, then sequential fetch
        rst_n = 1'b1;
        check("boot_fv", 64'(fetch_valid), 64'h0);
        step();
        check("run_state", 64'(dbg_state), 64'(ST_RUN));
        check("run_fv", 64'(fetch_valid), 64'h1);
        check("run_rr", 64'(redir_ready), 64'h1);
        check("seq_pc0", 64'(fetch_pc), 64'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq_pc", 64'(fetch_pc), 64'(4 * i));
        end

        // Stall at 0x10 for three cycles
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", 64'(fetch_pc), 64'h10);
        end
        fetch_ready = 1'b1;
        step();
        check("stall_release_pc", 64'(fetch_pc), 64'h14);

        // Branch backwards by one word
        redir(2'b00, 32'h100, 16'hFFFF, 26'h0, 32'h0);
        step();
        check("branch_pc", 64'(fetch_pc), 64'hFC);

        // Jump keeps the top base bits
        redir(2'b01, 32'hA000_0004, 16'h0, 26'h10, 32'h0);
        step();
        check("jump_pc", 64'(fetch_pc), 64'hA000_0040);

        // Misaligned register target
        redir(2'b10, 32'h0, 16'h0, 26'h0, 32'h203);
        step();
        check("reg_pc", 64'(fetch_pc), 64'h200);
        check("reg_misalign", 64'(misalign), 64'h1);
        redir_valid = 1'b0;
        step();
        check("reg_misalign_clr", 64'(misalign), 64'h0);
        check("reg_next_pc", 64'(fetch_pc), 64'h204);

        // Reserved kind: accepted, no PC change, no pulse, even with misaligned reg field
        fetch_ready = 1'b0;
        redir(2'b11, 32'h1234, 16'h7, 26'h5, 32'h203);
        step();
        check("rsvd_pc", 64'(fetch_pc), 64'h204);
        check("rsvd_misalign", 64'(misalign), 64'h0);

        // Redirect while fetch stalled
        redir(2'b00, 32'h1000, 16'h0004, 26'h0, 32'h0);
        step();
        check("redir_stall_pc", 64'(fetch_pc), 64'h1010);

        // Wrap at the top of the address space
        redir(2'b10, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        step();
        check("wrap_setup_pc", 64'(fetch_pc), 64'hFFFF_FFFC);
        check("wrap_setup_mis", 64'(misalign), 64'h0);
        redir_valid = 1'b0;
        fetch_ready = 1'b1;
        step();
        check("wrap_pc", 64'(fetch_pc), 64'h0);

        // Halt with fetch accepted: PC advances once, then frozen
        halt_req = 1'b1;
        step();
        check("halt_pc", 64'(fetch_pc), 64'h4);
        check("halt_halted", 64'(halted), 64'h1);
        check("halt_fv", 64'(fetch_valid), 64'h0);
        step();
        check("halt_hold_pc", 64'(fetch_pc), 64'h4);
        check("halt_rr", 64'(redir_ready), 64'h1);

        // Redirect while halted stays halted
        redir(2'b00, 32'h300, 16'h0, 26'h0, 32'h0);
        step();
        check("halt_redir_pc", 64'(fetch_pc), 64'h300);
        check("halt_redir_halted", 64'(halted), 64'h1);
        redir_valid = 1'b0;
        halt_req    = 1'b0;
        step();
        check("resume_halted", 64'(halted), 64'h0);
        check("resume_fv", 64'(fetch_valid), 64'h1);
        check("resume_pc", 64'(fetch_pc), 64'h300);
        step();
        check("resume_next_pc", 64'(fetch_pc), 64'h304);

        // Halt request without any acceptance keeps running
        halt_req    = 1'b1;
        fetch_ready = 1'b0;
        step();
        check("halt_blocked_halted", 64'(halted), 64'h0);
        check("halt_blocked_pc", 64'(fetch_pc), 64'h304);
        halt_req = 1'b0;

`ifdef PC_SEQ_EXC_EN
        // Exception beats a simultaneous redirect
        redir(2'b10, 32'h0, 16'h0, 26'h0, 32'h40);
        step();
        check("exc_setup_pc", 64'(fetch_pc), 64'h40);
        redir(2'b00, 32'h100, 16'h0, 26'h0, 32'h0);
        exc_req = 1'b1;
        step();
        check("exc_pc", 64'(fetch_pc), 64'h8000_0180);
        check("exc_epc", 64'(epc), 64'h40);
        check("exc_state", 64'(dbg_state), 64'(ST_RUN));
        exc_req     = 1'b0;
        redir_valid = 1'b0;
`endif

        // Asynchronous reset mid-operation with a redirect in flight
        fetch_ready = 1'b1;
        redir(2'b00, 32'h500, 16'h0, 26'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_pc", 64'(fetch_pc), 64'h0);
        check("midrst_state", 64'(dbg_state), 64'(ST_BOOT));
        check("midrst_fv", 64'(fetch_valid), 64'h0);
        check("midrst_rr", 64'(redir_ready), 64'h0);
        step();
        check("midrst_hold_pc", 64'(fetch_pc), 64'h0);
        redir_valid = 1'b0;
        rst_n       = 1'b1;
        step();
        step();
        check("post_rst_pc", 64'(fetch_pc), 64'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
